// File: rtl/cic_pkg.sv
// Shared constants, bank select encodings and FSM states for the CIC memory responder.
package cic_pkg;

    localparam int unsigned DW        = 20;
    localparam int unsigned IMG_AW    = 12;
    localparam int unsigned IMG_DEPTH = 4096;
    localparam int unsigned L0_DEPTH  = 4096;
    localparam int unsigned L1_DEPTH  = 1024;
    localparam int unsigned L2_DEPTH  = 2048;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned NBANK     = 5;

    typedef enum logic [SEL_W-1:0] {
        NSEL = 3'd0,
        L0K0 = 3'd1,
        L0K1 = 3'd2,
        L1K0 = 3'd3,
        L1K1 = 3'd4,
        L2F  = 3'd5
    } csel_e;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_READY,
        ST_SERVE,
        ST_DONE
    } state_e;

    // Depth of a result bank; 0 marks an unmapped select code.
    function automatic int unsigned bank_depth(input logic [SEL_W-1:0] sel);
        case (sel)
            L0K0, L0K1: return L0_DEPTH;
            L1K0, L1K1: return L1_DEPTH;
            L2F:        return L2_DEPTH;
            default:    return 0;
        endcase
    endfunction

    function automatic logic addr_ok(input logic [SEL_W-1:0] sel, input logic [IMG_AW-1:0] addr);
        return 32'(addr) < bank_depth(sel);
    endfunction

endpackage

// File: rtl/cic_bank_ram.sv
// Single-write, dual synchronous-read RAM; reads return the pre-write word on a collision.
module cic_bank_ram #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned W     = 20,
    parameter int unsigned AW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re_a,
    input  logic [AW-1:0] raddr_a,
    output logic [W-1:0]  rdata_a,
    input  logic          re_b,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_b
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read registers hold their value while the port is idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) begin
                rdata_a <= mem[raddr_a];
            end
            if (re_b) begin
                rdata_b <= mem[raddr_b];
            end
        end
    end

endmodule

// File: rtl/cic_mem_responder.sv
// Image and result-bank responder for the CIC conv engine.
// Define CIC_RESP_ERRCHK_EN to add the sticky err flag and saturating err_cnt.
module cic_mem_responder
    import cic_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              img_we,
    input  logic [IMG_AW-1:0] img_waddr,
    input  logic [DW-1:0]     img_wdata,
    input  logic              load_done,
    output logic              ready,
    input  logic              busy,
    input  logic [IMG_AW-1:0] iaddr,
    output logic [DW-1:0]     idata,
    input  logic [SEL_W-1:0]  csel,
    input  logic              cwr,
    input  logic [IMG_AW-1:0] caddr_wr,
    input  logic [DW-1:0]     cdata_wr,
    input  logic              crd,
    input  logic [IMG_AW-1:0] caddr_rd,
    output logic [DW-1:0]     cdata_rd,
    output logic              done,
    input  logic              dbg_rd,
    input  logic [SEL_W-1:0]  dbg_sel,
    input  logic [IMG_AW-1:0] dbg_addr,
    output logic [DW-1:0]     dbg_data
`ifdef CIC_RESP_ERRCHK_EN
    ,
    output logic              err,
    output logic [7:0]        err_cnt
`endif
);

    state_e           state;
    logic             img_wr;
    logic [DW-1:0]    img_rd_unused;
    logic [SEL_W-1:0] rd_sel_q;
    logic [SEL_W-1:0] dbg_sel_q;
    logic [DW-1:0]    rd_a [1:NBANK];
    logic [DW-1:0]    rd_b [1:NBANK];

    assign img_wr = img_we && (state != ST_SERVE) && !reset;

    cic_bank_ram #(.DEPTH(IMG_DEPTH), .W(DW), .AW(IMG_AW)) u_img (
        .clk     (clk),
        .reset   (reset),
        .we      (img_wr),
        .waddr   (img_waddr),
        .wdata   (img_wdata),
        .re_a    (state == ST_SERVE),
        .raddr_a (iaddr),
        .rdata_a (idata),
        .re_b    (1'b0),
        .raddr_b ('0),
        .rdata_b (img_rd_unused)
    );

    for (genvar b = 1; b <= NBANK; b++) begin : g_bank
        localparam int unsigned DEPTH = bank_depth(3'(b));
        localparam int unsigned AW    = $clog2(DEPTH);
        logic we, re_a, re_b;

        assign we   = !reset && cwr && (csel == 3'(b)) && addr_ok(csel, caddr_wr);
        assign re_a = crd && (csel == 3'(b)) && addr_ok(csel, caddr_rd);
        assign re_b = dbg_rd && (dbg_sel == 3'(b)) && addr_ok(dbg_sel, dbg_addr);

        cic_bank_ram #(.DEPTH(DEPTH), .W(DW), .AW(AW)) u_ram (
            .clk     (clk),
            .reset   (reset),
            .we      (we),
            .waddr   (caddr_wr[AW-1:0]),
            .wdata   (cdata_wr),
            .re_a    (re_a),
            .raddr_a (caddr_rd[AW-1:0]),
            .rdata_a (rd_a[b]),
            .re_b    (re_b),
            .raddr_b (dbg_addr[AW-1:0]),
            .rdata_b (rd_b[b])
        );
    end

    // Remember which bank answered; illegal reads latch NSEL so the output reads as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sel_q  <= NSEL;
            dbg_sel_q <= NSEL;
        end else begin
            if (crd) begin
                rd_sel_q <= addr_ok(csel, caddr_rd) ? csel : NSEL;
            end
            if (dbg_rd) begin
                dbg_sel_q <= addr_ok(dbg_sel, dbg_addr) ? dbg_sel : NSEL;
            end
        end
    end

    always_comb begin
        cdata_rd = '0;
        dbg_data = '0;
        for (int b = 1; b <= int'(NBANK); b++) begin
            if (rd_sel_q == 3'(b)) begin
                cdata_rd = rd_a[b];
            end
            if (dbg_sel_q == 3'(b)) begin
                dbg_data = rd_b[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
            ready <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: if (load_done) begin
                    state <= ST_READY;
                    ready <= 1'b1;
                end
                ST_READY: if (busy) begin
                    state <= ST_SERVE;
                    ready <= 1'b0;
                end
                ST_SERVE: if (!busy) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: if (load_done) begin
                    state <= ST_READY;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

`ifdef CIC_RESP_ERRCHK_EN
    logic busy_q;
    logic illegal;

    assign illegal = (cwr && !addr_ok(csel, caddr_wr)) ||
                     (crd && !addr_ok(csel, caddr_rd)) ||
                     (busy && !busy_q && (state != ST_READY));

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            busy_q <= busy;
            if (illegal) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cic_mem_responder.sv
// Scoreboard bench for cic_mem_responder: per-cycle reference model feeds a checking monitor.
module tb_cic_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        img_we = 1'b0;
    logic [11:0] img_waddr = '0;
    logic [19:0] img_wdata = '0;
    logic        load_done = 1'b0;
    logic        ready;
    logic        busy = 1'b0;
    logic [11:0] iaddr = '0;
    logic [19:0] idata;
    logic [2:0]  csel = '0;
    logic        cwr = 1'b0;
    logic [11:0] caddr_wr = '0;
    logic [19:0] cdata_wr = '0;
    logic        crd = 1'b0;
    logic [11:0] caddr_rd = '0;
    logic [19:0] cdata_rd;
    logic        done;
    logic        dbg_rd = 1'b0;
    logic [2:0]  dbg_sel = '0;
    logic [11:0] dbg_addr = '0;
    logic [19:0] dbg_data;
`ifdef CIC_RESP_ERRCHK_EN
    logic        err;
    logic [7:0]  err_cnt;
`endif

    cic_mem_responder dut (
        .clk(clk), .reset(reset), .img_we(img_we), .img_waddr(img_waddr), .img_wdata(img_wdata),
        .load_done(load_done), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
        .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .done(done), .dbg_rd(dbg_rd),
        .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef CIC_RESP_ERRCHK_EN
        , .err(err), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        ready;
        logic        done;
        logic [19:0] idata;
        logic [19:0] cdata;
        logic [19:0] dbg;
        logic        err;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    // Reference model state: phase 0 load, 1 ready, 2 serve, 3 done.
    logic [19:0] m_img [4096];
    logic [19:0] m_bank [8][4096];
    int          m_phase = 0;
    logic        m_ready = 1'b0, m_done = 1'b0, m_busy_q = 1'b0, m_err = 1'b0;
    logic [19:0] m_idata = '0, m_cd = '0, m_dbg = '0;
    int          m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dep(input int s);
        case (s)
            1, 2:    return 4096;
            3, 4:    return 1024;
            5:       return 2048;
            default: return 0;
        endcase
    endfunction

    function automatic bit ok(input int s, input int a);
        return a < dep(s);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Apply the current inputs for one clock, predicting outputs visible after the edge.
    task automatic step();
        exp_t e;
        bit   ill;
        if (reset) begin
            m_phase = 0; m_ready = 0; m_done = 0; m_busy_q = 0; m_err = 0; m_cnt = 0;
            m_idata = '0; m_cd = '0; m_dbg = '0;
        end else begin
            ill = (cwr && !ok(int'(csel), int'(caddr_wr))) || (crd && !ok(int'(csel), int'(caddr_rd)))
                  || (busy && !m_busy_q && m_phase != 1);
            if (m_phase == 2) m_idata = m_img[iaddr];
            if (crd) m_cd = ok(int'(csel), int'(caddr_rd)) ? m_bank[csel][caddr_rd] : 20'd0;
            if (dbg_rd) m_dbg = ok(int'(dbg_sel), int'(dbg_addr)) ? m_bank[dbg_sel][dbg_addr] : 20'd0;
            if (img_we && m_phase != 2) m_img[img_waddr] = img_wdata;
            if (cwr && ok(int'(csel), int'(caddr_wr))) m_bank[csel][caddr_wr] = cdata_wr;
            case (m_phase)
                0: if (load_done) begin m_phase = 1; m_ready = 1; end
                1: if (busy) begin m_phase = 2; m_ready = 0; end
                2: if (!busy) begin m_phase = 3; m_done = 1; end
                default: if (load_done) begin m_phase = 1; m_ready = 1; m_done = 0; end
            endcase
            if (ill) begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
            end
            m_busy_q = busy;
        end
        e.due = cyc + 1; e.ready = m_ready; e.done = m_done; e.idata = m_idata;
        e.cdata = m_cd; e.dbg = m_dbg; e.err = m_err; e.cnt = 8'(m_cnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    exp_t got;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            got = sb.pop_front();
            check("ready", 32'(ready), 32'(got.ready));
            check("done", 32'(done), 32'(got.done));
            check("idata", 32'(idata), 32'(got.idata));
            check("cdata_rd", 32'(cdata_rd), 32'(got.cdata));
            check("dbg_data", 32'(dbg_data), 32'(got.dbg));
`ifdef CIC_RESP_ERRCHK_EN
            check("err", 32'(err), 32'(got.err));
            check("err_cnt", 32'(err_cnt), 32'(got.cnt));
`endif
        end
    end

    task automatic idle();
        img_we = 0; load_done = 0; cwr = 0; crd = 0; dbg_rd = 0;
    endtask

    function automatic logic [11:0] pick_addr(input int s);
        case ($urandom_range(3))
            0:       return 12'($urandom);
            1:       return 12'(dep(s) - 1);
            2:       return 12'(dep(s));
            default: return 12'($urandom_range(15));
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        reset = 1; step(); step();
        reset = 0;
        // Clear every result bank so later reads are defined.
        cwr = 1; cdata_wr = '0;
        for (int s = 1; s <= 5; s++) begin
            csel = 3'(s);
            for (int a = 0; a < dep(s); a++) begin caddr_wr = 12'(a); step(); end
        end
        cwr = 0;
        // Image load, last write coincident with load_done.
        img_we = 1;
        for (int i = 0; i < 4096; i++) begin
            img_waddr = 12'(i); img_wdata = 20'(i + 32'h100);
            load_done = (i == 4095);
            step();
        end
        idle(); step();
        busy = 1; step();
        iaddr = 12'h03F; step();
        // Result bank write/read, isolation and out-of-range cases.
        csel = 1; cwr = 1; caddr_wr = 5; cdata_wr = 20'hABCDE; step();
        cwr = 0; crd = 1; caddr_rd = 5; step();
        csel = 2; step();
        crd = 0; step();
        csel = 3; cwr = 1; caddr_wr = 1024; cdata_wr = 20'h55555; step();
        cwr = 0; crd = 1; caddr_rd = 1024; step();
        cwr = 1; crd = 0; caddr_wr = 1023; cdata_wr = 20'h12345; step();
        cwr = 0; crd = 1; caddr_rd = 1023; step();
        csel = 5; crd = 0; cwr = 1; caddr_wr = 7; cdata_wr = 20'h11111; step();
        crd = 1; caddr_rd = 7; cdata_wr = 20'h22222; step();
        cwr = 0; step();
        crd = 0;
        for (int i = 0; i < 100; i++) begin iaddr = 12'($urandom); step(); end
        busy = 0; step(); step();
        load_done = 1; step();
        load_done = 0; busy = 1; step(); step(); step();
        reset = 1; step();
        reset = 0; busy = 0; step();
        dbg_rd = 1; dbg_sel = 1; dbg_addr = 5; step();
        dbg_rd = 0; csel = 0; cwr = 1; caddr_wr = 9;
        step(); step(); step();
        cwr = 0; step();
        // Randomized traffic across all states.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(199) == 0);
            img_we    = ($urandom_range(3) == 0);
            img_waddr = 12'($urandom);
            img_wdata = 20'($urandom);
            load_done = ($urandom_range(29) == 0);
            if ($urandom_range(19) == 0) busy = ~busy;
            iaddr     = 12'($urandom);
            csel      = 3'($urandom_range(7));
            cwr       = ($urandom_range(2) == 0);
            caddr_wr  = pick_addr(int'(csel));
            cdata_wr  = 20'($urandom);
            crd       = ($urandom_range(1) == 0);
            caddr_rd  = ($urandom_range(3) == 0) ? caddr_wr : pick_addr(int'(csel));
            dbg_rd    = ($urandom_range(1) == 0);
            dbg_sel   = 3'($urandom_range(7));
            dbg_addr  = pick_addr(int'(dbg_sel));
            step();
        end
        reset = 0; busy = 0; idle(); step(); step();
        @(negedge clk); #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cic_mem_responder.md
Name: cic_mem_responder

Overview:
- Responder side of the CIC conv-engine protocol.
- Holds the 64x64 grayscale source image and serves idata for iaddr while busy is high.
- Owns the five result banks selected by csel and services cwr writes and crd reads from the engine.
- Sits between the image loader/host and the engine; it replaces the behavioural bench memories with synthesizable RTL.

Parameters:
- DW, 20, pixel/result word width
- IMG_AW, 12, image address width (4096 words)
- L1_DEPTH, 1024, depth of the L1K0 and L1K1 banks (max-pool 32x32)
- L2_DEPTH, 2048, depth of the L2F flatten bank

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- img_we  in  1  host image write strobe
- img_waddr  in  12  host image write address
- img_wdata  in  DW  host image pixel
- load_done  in  1  pulse: image load complete
- ready  out  1  image ready for engine
- busy  in  1  engine fetch/compute in progress
- iaddr  in  12  image read address
- idata  out  DW  image pixel
- csel  in  3  bank select: 0 none, 1 L0K0, 2 L0K1, 3 L1K0, 4 L1K1, 5 L2F
- cwr  in  1  result write enable
- caddr_wr  in  12  result write address
- cdata_wr  in  DW  result write data
- crd  in  1  result read enable
- caddr_rd  in  12  result read address
- cdata_rd  out  DW  result read data
- done  out  1  engine finished (busy fell)
- dbg_rd  in  1  host readback strobe
- dbg_sel  in  3  host readback bank
- dbg_addr  in  12  host readback address
- dbg_data  out  DW  host readback data

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, sampled on posedge clk.
- Reset values: ready=0, idata=0, cdata_rd=0, done=0, dbg_data=0, state=LOAD. Memory contents are not cleared.
- FSM states: LOAD, READY, SERVE, DONE.
  - LOAD: img_we writes img_wdata to the image RAM at img_waddr. load_done -> READY.
  - READY: ready=1. busy sampled 1 -> SERVE with ready=0 on the next cycle. img_we is still accepted.
  - SERVE: img_we and load_done are ignored. busy sampled 0 -> DONE.
  - DONE: done=1 and held. img_we is accepted. load_done -> READY with done=0.
  - load_done and img_we in the same cycle: the write completes and the transition occurs.
- Image read (every cycle in SERVE): idata <= img[iaddr]. Latency 1 cycle; the engine presents iaddr in cycle N and idata is valid in N+1. Outside SERVE, idata holds its last value.
- Result write: when cwr=1 and csel is 1..5, write bank[csel][caddr_wr] <= cdata_wr.
  - csel=0 or 6/7: write ignored.
  - Write address >= bank depth: write ignored (no wrap).
- Result read: when crd=1, cdata_rd <= bank[csel][caddr_rd]. Latency 1 cycle.
  - Returns 0 for csel 0/6/7 or an address >= depth.
  - When crd=0, cdata_rd holds its value.
- cwr and crd in the same cycle, same bank, same address: the read returns the old data (read-before-write).
- cwr/crd are honoured in every state; the engine owns timing.
- dbg port: same rules as crd, 1-cycle latency, independent of crd. Implemented as a second read port of each bank.
- Bank depths: L0K0/L0K1 are 4096, L1K0/L1K1 are L1_DEPTH, L2F is L2_DEPTH.
- Reset mid-SERVE: return to LOAD with ready=0 and done=0; image and result contents are retained.

Optional Feature:
- Macro: CIC_RESP_ERRCHK_EN.
- Defined: adds output err (1 bit, sticky until reset) and err_cnt (8 bits, saturating at 255).
  - Each cycle with an illegal access sets err and increments err_cnt by one.
  - Illegal access: cwr or crd with csel in {0,6,7}, an out-of-range address, or a busy rise outside READY.
- Undefined: ports absent, no checking logic.

Decomposition:
- Package cic_pkg holds:
  - csel encodings NSEL, L0K0, L0K1, L1K0, L1K1, L2F;
  - depth constants;
  - the FSM state enum;
  - DW.
- Sub-module cic_bank_ram (parameterised depth/width): one write port, two synchronous read ports (read-before-write).
  - Instantiated once for the image and five times for the result banks.

Test Plan:
- Load img[i]=i+0x100 for all 4096, pulse load_done -> ready=1 next cycle; busy=1 -> ready=0 one cycle later; iaddr=0x03F -> idata=0x0013F next cycle.
- csel=1, cwr, caddr_wr=5, cdata_wr=0xABCDE; then crd, caddr_rd=5 -> cdata_rd=0xABCDE one cycle after crd. Same read with csel=2 -> 0 (bank isolation).
- csel=3, cwr at caddr_wr=1024 -> ignored; crd at 1024 -> cdata_rd=0. Address 1023 round-trips 0x12345.
- Same cycle cwr and crd on csel=5, address 7, old data 0x11111, new data 0x22222 -> cdata_rd=0x11111; next read -> 0x22222.
- busy high for 100 cycles, then low -> done=1 in the following cycle. Assert reset mid-SERVE -> ready=0 and done=0; dbg read of L0K0[5] still returns 0xABCDE.
- With CIC_RESP_ERRCHK_EN: cwr with csel=0 for 3 cycles -> err=1, err_cnt=3. Without the macro the build omits both ports.
